algorithm_select: RTL and testbench
===================================

Name: algorithm_select

Overview:
- Upstream front-end that produces the 2-bit ALGORITHM code consumed by the 7-segment display decoder and the scaling coprocessor (0=NN, 1=PR, 2=DC, 3=BA).
- Synchronizes and debounces two active-low push-buttons; NEXT cycles the algorithm and START launches an operation.
- Runs a START/BUSY handshake with the coprocessor and freezes the selection while an operation is in flight.

Parameters:
- DEBOUNCE_CYCLES, 500000: stable-level cycles required before a key change is accepted (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 1000: maximum cycles in REQ waiting for BUSY before abort.
- CNT_W, 20: width of debounce and timeout counters; must hold max(DEBOUNCE_CYCLES, TIMEOUT_CYCLES).

Ports:
- CLOCK_50  in  1  system clock; all state is on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- KEY_NEXT_N  in  1  raw push-button, active-low, asynchronous to the clock.
- KEY_START_N  in  1  raw push-button, active-low, asynchronous to the clock.
- BUSY  in  1  coprocessor busy level.
- ALGORITHM  out  2  current algorithm code, drives the display decoder.
- START  out  1  request level to the coprocessor.
- LOCKED  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle pulse on operation completion.
- ERROR  out  1  sticky handshake-timeout flag.

Behaviour:
- Reset values: ALGORITHM=0, START=0, LOCKED=0, DONE=0, ERROR=0, state=IDLE, both debounced keys=released, all counters=0. Reset takes effect immediately (asynchronous) at any point, including mid-operation; START drops without waiting for a clock edge.
- Synchronizer: a 2-flop chain per key.
- Debounce, per key:
  - The counter clears whenever the synchronized level equals the stable level; otherwise it increments.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, the stable level takes the synchronized level and the counter clears.
  - A press event is a one-cycle pulse on the stable released->pressed transition. A held key gives exactly one event; the release gives none.
  - Key-to-event latency is 2 + DEBOUNCE_CYCLES cycles from the first clean edge.
- FSM states: IDLE, REQ, RUN.
  - IDLE, NEXT event: ALGORITHM <= ALGORITHM+1 mod 4 (3 wraps to 0).
  - IDLE, START event: START <= 1, ERROR <= 0, timeout counter <= 0, go to REQ.
  - IDLE, NEXT and START events in the same cycle: START wins; ALGORITHM is unchanged.
  - REQ: hold START=1.
    - BUSY=1 sampled: START <= 0, go to RUN.
    - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYCLES-1: START <= 0, ERROR <= 1, go to IDLE.
  - RUN, BUSY=0 sampled: DONE=1 for exactly one cycle, go to IDLE.
  - NEXT and START events in REQ or RUN are discarded, not queued. ALGORITHM is stable from the START event until the return to IDLE.
  - BUSY already high at the START event: REQ lasts exactly one cycle.
- LOCKED is registered and equals (state != IDLE); it rises the cycle after the START event.
- ERROR stays set until the next accepted START event or reset.
- Outputs are registered; none depend combinationally on inputs.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8, CNT_W=4):
- Reset, then four clean NEXT presses, each held 10 cycles -> ALGORITHM steps 1,2,3,0; each step occurs 6 cycles after the press edge; no change on release.
- NEXT toggling every 2 cycles for 20 cycles, then held low -> exactly one increment, only after 4 stable cycles.
- START press with BUSY asserted 3 cycles after START rises and held for 10 cycles -> START high 3 cycles then low; LOCKED high throughout; DONE one pulse the cycle after BUSY falls; NEXT presses during RUN leave ALGORITHM unchanged.
- START press with BUSY held 0 -> START drops after 8 cycles in REQ; ERROR=1 and state IDLE; a second START press clears ERROR.
- NEXT and START debounced events coincide with ALGORITHM=2 -> ALGORITHM stays 2 and the FSM enters REQ.
- RESET asserted mid-RUN with ALGORITHM=3 -> all outputs zero asynchronously; after release the FSM is in IDLE and a BUSY fall produces no DONE pulse.

Source files
------------

// File: rtl/algorithm_select.sv
// Algorithm selector front-end: synchronizes and debounces the NEXT/START
// push-buttons, cycles the 2-bit algorithm code and runs the START/BUSY
// handshake with the scaling coprocessor.
module algorithm_select #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       KEY_NEXT_N,
    input  logic       KEY_START_N,
    input  logic       BUSY,
    output logic [1:0] ALGORITHM,
    output logic       START,
    output logic       LOCKED,
    output logic       DONE,
    output logic       ERROR
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned      KEY_NEXT  = 0;
    localparam int unsigned      KEY_START = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Key pipeline: bit 0 is NEXT, bit 1 is START; level 1 means released.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       press_c;

    state_t           state_q, state_d;
    logic [1:0]       alg_q, alg_d;
    logic             start_q, start_d;
    logic             locked_q, locked_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    // Two-flop synchronizer feeding the debounce stage.
    always_comb begin
        sync1_d = {KEY_START_N, KEY_NEXT_N};
        sync2_d = sync1_q;
    end

    // Debounce: accept a new level only after it has persisted DEBOUNCE_CYCLES samples.
    always_comb begin
        stable_d = stable_q;
        press_c  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    press_c[i]  = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Handshake FSM next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        alg_d   = alg_q;
        start_d = start_q;
        done_d  = 1'b0;
        error_d = error_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (press_c[KEY_START]) begin
                    start_d = 1'b1;
                    error_d = 1'b0;
                    tmo_d   = '0;
                    state_d = REQ;
                end else if (press_c[KEY_NEXT]) begin
                    alg_d = alg_q + 2'd1;
                end
            end
            REQ: begin
                if (BUSY) begin
                    start_d = 1'b0;
                    state_d = RUN;
                end else if (tmo_q == TMO_LAST) begin
                    start_d = 1'b0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!BUSY) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        locked_d = (state_d != IDLE);
    end

    // All state on the rising clock; reset is asynchronous.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            state_q  <= IDLE;
            alg_q    <= 2'd0;
            start_q  <= 1'b0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            state_q  <= state_d;
            alg_q    <= alg_d;
            start_q  <= start_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            error_q  <= error_d;
            tmo_q    <= tmo_d;
        end
    end

    assign ALGORITHM = alg_q;
    assign START     = start_q;
    assign LOCKED    = locked_q;
    assign DONE      = done_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_algorithm_select.sv
// Bench for algorithm_select: directed plan plus random key/busy traffic,
// checked every cycle against a sample-history reference model.
module tb_algorithm_select;

    localparam int unsigned D = 4;
    localparam int unsigned T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kn  = 1'b1;
    logic       ks  = 1'b1;
    logic       busy = 1'b0;
    logic [1:0] alg;
    logic       start_o, locked_o, done_o, error_o;

    int checks = 0;
    int passed = 0;

    // Reference model state
    bit         h_n[$];
    bit         h_s[$];
    bit         st_n, st_s;
    int         m_mode;   // 0 idle, 1 waiting for busy, 2 running
    logic [1:0] m_alg;
    bit         m_start, m_locked, m_done, m_err;
    int         m_wait;

    algorithm_select #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (4)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .KEY_NEXT_N (kn),
        .KEY_START_N(ks),
        .BUSY       (busy),
        .ALGORITHM  (alg),
        .START      (start_o),
        .LOCKED     (locked_o),
        .DONE       (done_o),
        .ERROR      (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        h_n.delete();
        h_s.delete();
        for (int i = 0; i < int'(D) + 2; i++) begin
            h_n.push_back(1'b1);
            h_s.push_back(1'b1);
        end
        st_n = 1'b1; st_s = 1'b1;
        m_mode = 0; m_alg = 2'd0;
        m_start = 0; m_locked = 0; m_done = 0; m_err = 0; m_wait = 0;
    endtask

    // True when the D samples that have cleared the synchronizer all differ from the stable level.
    function automatic bit settled_change(input bit h[$], input bit stab);
        bit all_diff = 1'b1;
        for (int k = 0; k < int'(D); k++)
            if (h[k] == stab) all_diff = 1'b0;
        return all_diff;
    endfunction

    task automatic model_edge();
        bit ev_n, ev_s;
        if (rst) begin
            model_reset();
            return;
        end
        h_n.push_back(kn); void'(h_n.pop_front());
        h_s.push_back(ks); void'(h_s.pop_front());
        ev_n = 0; ev_s = 0;
        if (settled_change(h_n, st_n)) begin st_n = !st_n; ev_n = !st_n; end
        if (settled_change(h_s, st_s)) begin st_s = !st_s; ev_s = !st_s; end
        m_done = 0;
        case (m_mode)
            0: begin
                if (ev_s) begin
                    m_start = 1; m_err = 0; m_wait = 0; m_mode = 1;
                end else if (ev_n) begin
                    m_alg = m_alg + 2'd1;
                end
            end
            1: begin
                if (busy) begin
                    m_start = 0; m_mode = 2;
                end else if (m_wait == int'(T) - 1) begin
                    m_start = 0; m_err = 1; m_mode = 0;
                end else begin
                    m_wait++;
                end
            end
            default: begin
                if (!busy) begin
                    m_done = 1; m_mode = 0;
                end
            end
        endcase
        m_locked = (m_mode != 0);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_alg"},    32'(alg),      32'(m_alg));
        check({tag, "_start"},  32'(start_o),  32'(m_start));
        check({tag, "_locked"}, 32'(locked_o), 32'(m_locked));
        check({tag, "_done"},   32'(done_o),   32'(m_done));
        check({tag, "_error"},  32'(error_o),  32'(m_err));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
        steps(3, "post_reset");

        // Four clean NEXT presses: step lands on the 6th edge after the press.
        for (int p = 0; p < 4; p++) begin
            kn = 1'b0;
            steps(5, "next_wait");
            check("next_before", 32'(alg), 32'(p));
            step("next_edge");
            check("next_after", 32'(alg), 32'((p + 1) % 4));
            steps(4, "next_hold");
            kn = 1'b1;
            steps(10, "next_release");
            check("next_release_alg", 32'(alg), 32'((p + 1) % 4));
        end

        // Bouncing NEXT: only the final stable press counts.
        for (int i = 0; i < 10; i++) begin
            kn = ~kn;
            steps(2, "bounce");
        end
        check("bounce_no_step", 32'(alg), 32'd0);
        kn = 1'b0;
        steps(5, "bounce_hold");
        check("bounce_hold_before", 32'(alg), 32'd0);
        step("bounce_hold_edge");
        check("bounce_one_step", 32'(alg), 32'd1);
        kn = 1'b1;
        steps(10, "bounce_release");

        // START with BUSY arriving three cycles after START rises.
        ks = 1'b0;
        steps(5, "start_wait");
        check("start_not_yet", 32'(start_o), 32'd0);
        step("start_edge");
        check("start_rise", 32'(start_o), 32'd1);
        check("locked_rise", 32'(locked_o), 32'd1);
        ks = 1'b1;
        steps(2, "req_hold");
        check("start_held", 32'(start_o), 32'd1);
        busy = 1'b1;
        step("busy_seen");
        check("start_drop", 32'(start_o), 32'd0);
        check("locked_run", 32'(locked_o), 32'd1);
        kn = 1'b0;
        steps(6, "next_in_run");
        kn = 1'b1;
        steps(3, "run_hold");
        check("run_alg_frozen", 32'(alg), 32'd1);
        busy = 1'b0;
        step("done_edge");
        check("done_pulse", 32'(done_o), 32'd1);
        check("locked_fall", 32'(locked_o), 32'd0);
        step("done_after");
        check("done_single", 32'(done_o), 32'd0);
        steps(8, "run_settle");
        check("run_alg_still", 32'(alg), 32'd1);

        // START with no BUSY: timeout after T cycles in REQ.
        ks = 1'b0;
        steps(6, "tmo_start");
        check("tmo_start_hi", 32'(start_o), 32'd1);
        ks = 1'b1;
        steps(7, "tmo_wait");
        check("tmo_start_still", 32'(start_o), 32'd1);
        step("tmo_edge");
        check("tmo_start_low", 32'(start_o), 32'd0);
        check("tmo_error", 32'(error_o), 32'd1);
        check("tmo_unlocked", 32'(locked_o), 32'd0);
        steps(4, "tmo_idle");
        ks = 1'b0;
        steps(6, "clear_start");
        check("error_cleared", 32'(error_o), 32'd0);
        ks = 1'b1;
        busy = 1'b1;
        step("clear_busy");
        busy = 1'b0;
        steps(10, "clear_done");

        // Coincident NEXT and START with ALGORITHM=2: START wins.
        kn = 1'b0;
        steps(6, "to_two");
        kn = 1'b1;
        steps(10, "to_two_rel");
        check("alg_two", 32'(alg), 32'd2);
        kn = 1'b0; ks = 1'b0;
        steps(6, "coincide");
        check("coincide_alg", 32'(alg), 32'd2);
        check("coincide_req", 32'(start_o), 32'd1);
        kn = 1'b1; ks = 1'b1;
        busy = 1'b1;
        step("coincide_busy");
        busy = 1'b0;
        steps(10, "coincide_done");

        // Reset mid-RUN with ALGORITHM=3.
        kn = 1'b0;
        steps(6, "to_three");
        kn = 1'b1;
        steps(10, "to_three_rel");
        check("alg_three", 32'(alg), 32'd3);
        busy = 1'b1;
        ks = 1'b0;
        steps(7, "into_run");
        ks = 1'b1;
        check("in_run_locked", 32'(locked_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_alg", 32'(alg), 32'd0);
        check("async_start", 32'(start_o), 32'd0);
        check("async_locked", 32'(locked_o), 32'd0);
        check("async_done", 32'(done_o), 32'd0);
        check("async_error", 32'(error_o), 32'd0);
        step("reset_hold");
        rst = 1'b0;
        busy = 1'b0;
        step("post_rst_busy_fall");
        check("no_done_after_rst", 32'(done_o), 32'd0);
        steps(8, "post_rst_idle");

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = 1'b0;
            if ($urandom_range(0, 11) == 0) kn = ~kn;
            if ($urandom_range(0, 13) == 0) ks = ~ks;
            if ($urandom_range(0, 6) == 0) busy = ~busy;
            if ($urandom_range(0, 249) == 0) rst = 1'b1;
            step("random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
